// File: rtl/ex_pkg.sv
// ex_pkg: shared types and constants for the RV32 execute stage.
//   - XlenDefault : default datapath width
//   - alu_op_e    : ALUOp codes from the decoder
//   - Funct*      : {funct7, funct3} codes for the supported R-type ops
//   - F3*         : funct3 codes for the supported I-type ops
//   - state_e     : multiply sequencer states
package ex_pkg;

    localparam int unsigned XlenDefault = 32;

    typedef enum logic [1:0] {
        AluAdd   = 2'b00,
        AluSub   = 2'b01,
        AluRType = 2'b10,
        AluIType = 2'b11
    } alu_op_e;

    localparam logic [9:0] FunctAdd = 10'b0000000_000;
    localparam logic [9:0] FunctSub = 10'b0100000_000;
    localparam logic [9:0] FunctAnd = 10'b0000000_111;
    localparam logic [9:0] FunctOr  = 10'b0000000_110;
    localparam logic [9:0] FunctXor = 10'b0000000_100;
    localparam logic [9:0] FunctSll = 10'b0000000_001;
    localparam logic [9:0] FunctMul = 10'b0000001_000;

    localparam logic [2:0] F3Addi = 3'b000;
    localparam logic [2:0] F3Srai = 3'b101;

    typedef enum logic [0:0] {
        StIdle    = 1'b0,
        StMulBusy = 1'b1
    } state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX fields into the execute stage and EX/MEM fields out of it.
//   master : upstream side (drives the *_i fields, observes stall_o and the *_o fields)
//   slave  : execute stage side
interface ex_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            valid_i;
    logic [31:0]     PC_i;
    logic [XLEN-1:0] RSdata_i;
    logic [XLEN-1:0] RTdata_i;
    logic [XLEN-1:0] imm_i;
    logic [4:0]      RDaddr_i;
    logic [9:0]      funct_i;
    logic [1:0]      ALUOp_i;
    logic            ALUSrc_i;
    logic            Branch_i;
    logic            MemRead_i;
    logic            MemWrite_i;
    logic            RegWrite_i;
    logic            MemtoReg_i;

    logic            stall_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;
    logic [XLEN-1:0] store_data_o;
    logic [4:0]      RDaddr_o;
    logic            MemRead_o;
    logic            MemWrite_o;
    logic            RegWrite_o;
    logic            MemtoReg_o;
    logic            branch_taken_o;
    logic [31:0]     branch_target_o;

    modport master (
        output valid_i, PC_i, RSdata_i, RTdata_i, imm_i, RDaddr_i, funct_i, ALUOp_i,
               ALUSrc_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i,
        input  stall_o, valid_o, result_o, store_data_o, RDaddr_o, MemRead_o, MemWrite_o,
               RegWrite_o, MemtoReg_o, branch_taken_o, branch_target_o
    );

    modport slave (
        input  valid_i, PC_i, RSdata_i, RTdata_i, imm_i, RDaddr_i, funct_i, ALUOp_i,
               ALUSrc_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i,
        output stall_o, valid_o, result_o, store_data_o, RDaddr_o, MemRead_o, MemWrite_o,
               RegWrite_o, MemtoReg_o, branch_taken_o, branch_target_o
    );

endinterface

// File: rtl/ex_iter_mul.sv
// ex_iter_mul: iterative shift-add multiplier, one partial product per cycle.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   start          : load operands, clear accumulator and counter
//   busy           : perform one shift-add step this cycle
//   multiplicand   : first operand (sampled on start)
//   multiplier     : second operand (sampled on start)
//   last           : busy and this is the final step
//   product        : accumulator including this cycle's step (low XLEN bits)
module ex_iter_mul
    import ex_pkg::*;
#(
    parameter int unsigned XLEN       = XlenDefault,
    parameter int unsigned MUL_CYCLES = XlenDefault
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start,
    input  logic            busy,
    input  logic [XLEN-1:0] multiplicand,
    input  logic [XLEN-1:0] multiplier,
    output logic            last,
    output logic [XLEN-1:0] product
);

    localparam int unsigned    CntW    = $clog2(MUL_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(MUL_CYCLES - 1);

    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] acc_step;
    logic [CntW-1:0] cnt_q;

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    // Product is exposed combinationally so the final step can be registered
    // straight into the EX/MEM result without an extra cycle.
    assign product  = acc_step;
    assign last     = busy && (cnt_q == CntLast);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            mcand_q  <= multiplicand;
            mplier_q <= multiplier;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (busy) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage RV32 pipeline.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus (slave)  : ID/EX fields in, EX/MEM registered fields and stall_o out
// ALU ops, BEQ resolution and, with EX_MUL_EN defined, a 32-cycle iterative
// multiply that stalls upstream. Without EX_MUL_EN the mul code yields 0 and
// stall_o is tied low.
module ex_stage
    import ex_pkg::*;
#(
    parameter int unsigned XLEN       = XlenDefault,
    parameter int unsigned MUL_CYCLES = XlenDefault
) (
    input  logic       clk_i,
    input  logic       rst_i,
    ex_stage_if.slave  bus
);

    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] result_d;
    logic            stall;

    // Registered EX/MEM fields
    logic            valid_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] store_data_q;
    logic [4:0]      rd_addr_q;
    logic            mem_read_q;
    logic            mem_write_q;
    logic            reg_write_q;
    logic            mem_to_reg_q;
    logic            taken_q;
    logic [31:0]     target_q;

    assign op_b = bus.ALUSrc_i ? bus.imm_i : bus.RTdata_i;

    always_comb begin
        alu_result = '0;
        unique case (alu_op_e'(bus.ALUOp_i))
            AluAdd: alu_result = bus.RSdata_i + op_b;
            AluSub: alu_result = bus.RSdata_i - op_b;
            AluRType: begin
                case (bus.funct_i)
                    FunctAdd: alu_result = bus.RSdata_i + op_b;
                    FunctSub: alu_result = bus.RSdata_i - op_b;
                    FunctAnd: alu_result = bus.RSdata_i & op_b;
                    FunctOr:  alu_result = bus.RSdata_i | op_b;
                    FunctXor: alu_result = bus.RSdata_i ^ op_b;
                    FunctSll: alu_result = bus.RSdata_i << op_b[4:0];
                    // mul (handled by the iterative core) and unknown codes give 0
                    default:  alu_result = '0;
                endcase
            end
            AluIType: begin
                case (bus.funct_i[2:0])
                    F3Addi:  alu_result = bus.RSdata_i + op_b;
                    F3Srai:  alu_result = $unsigned($signed(bus.RSdata_i) >>> bus.imm_i[4:0]);
                    default: alu_result = '0;
                endcase
            end
            default: alu_result = '0;
        endcase
    end

`ifdef EX_MUL_EN
    state_e          state_q;
    state_e          state_d;
    logic            is_mul;
    logic            mul_start;
    logic            mul_busy;
    logic            mul_last;
    logic [XLEN-1:0] mul_product;

    assign is_mul = (alu_op_e'(bus.ALUOp_i) == AluRType) && (bus.funct_i == FunctMul);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        mul_busy  = 1'b0;
        stall     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.valid_i && is_mul) begin
                    mul_start = 1'b1;
                    stall     = 1'b1;
                    state_d   = StMulBusy;
                end
            end
            StMulBusy: begin
                mul_busy = 1'b1;
                // Drop the stall on the final step so upstream advances on the
                // same edge that registers the product.
                if (mul_last) begin
                    state_d = StIdle;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    ex_iter_mul #(
        .XLEN       (XLEN),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_iter_mul (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start        (mul_start),
        .busy         (mul_busy),
        .multiplicand (bus.RSdata_i),
        .multiplier   (op_b),
        .last         (mul_last),
        .product      (mul_product)
    );

    assign result_d = mul_last ? mul_product : alu_result;
`else
    logic unused_mul_cfg;
    assign unused_mul_cfg = ^MUL_CYCLES;
    assign stall          = 1'b0;
    assign result_d       = alu_result;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q      <= 1'b0;
            result_q     <= '0;
            store_data_q <= '0;
            rd_addr_q    <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            taken_q      <= 1'b0;
            target_q     <= '0;
        end else if (stall) begin
            // Multiply start/progress: push a bubble, keep the data fields.
            valid_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            taken_q      <= 1'b0;
        end else begin
            valid_q      <= bus.valid_i;
            result_q     <= result_d;
            store_data_q <= bus.RTdata_i;
            rd_addr_q    <= bus.RDaddr_i;
            mem_read_q   <= bus.valid_i & bus.MemRead_i;
            mem_write_q  <= bus.valid_i & bus.MemWrite_i;
            reg_write_q  <= bus.valid_i & bus.RegWrite_i;
            mem_to_reg_q <= bus.valid_i & bus.MemtoReg_i;
            taken_q      <= bus.valid_i & bus.Branch_i & (bus.RSdata_i == bus.RTdata_i);
            target_q     <= bus.PC_i + (bus.imm_i << 1);
        end
    end

    assign bus.stall_o         = stall;
    assign bus.valid_o         = valid_q;
    assign bus.result_o        = result_q;
    assign bus.store_data_o    = store_data_q;
    assign bus.RDaddr_o        = rd_addr_q;
    assign bus.MemRead_o       = mem_read_q;
    assign bus.MemWrite_o      = mem_write_q;
    assign bus.RegWrite_o      = reg_write_q;
    assign bus.MemtoReg_o      = mem_to_reg_q;
    assign bus.branch_taken_o  = taken_q;
    assign bus.branch_target_o = target_q;

endmodule
